// File: rtl/wb_core_bridge_pkg.sv
// wb_core_bridge_pkg: FSM states, the full-word byte-enable constant and the byte-merge helper.
package wb_core_bridge_pkg;
  typedef enum logic [2:0] {IDLE, READ, RMW, WRITE, ACK, ERR} state_t;
  localparam logic [3:0] SEL_FULL = 4'hF;
  function automatic logic [31:0] byte_merge(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] sel);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = sel[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return m;
  endfunction
endpackage

// File: rtl/wb_core_bridge_if.sv
// core_io: register-core side of the bridge; the bridge drives it through modport out.
interface core_io #(parameter int REGS = 3);
  logic                 clk;
  logic                 reset;
  logic [31:0]          data_in;
  logic [REGS-1:0]      write_en;
  logic [REGS-1:0]      read_en;
  logic [REGS-1:0][31:0] data_out;
  logic                 irq_out;
  modport out (output clk, reset, data_in, write_en, read_en, input data_out, irq_out);
  modport core (input clk, reset, data_in, write_en, read_en, output data_out, irq_out);
endinterface

// File: rtl/wb_core_bridge.sv
// wb_core_bridge: Wishbone slave to register core, with read-modify-write for partial writes.
// Define WB_CORE_BRIDGE_ERR_EN to answer out-of-range addresses with wb_err_o instead of an ack.
module wb_core_bridge
  import wb_core_bridge_pkg::*;
#(
  parameter int REGS         = 3,
  parameter int ADDRESSWIDTH = $clog2(REGS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [ADDRESSWIDTH-1:0] wb_adr_i,
  input  logic [31:0]             wb_dat_i,
  input  logic [3:0]              wb_sel_i,
  output logic [31:0]             wb_dat_o,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic                    irq_o,
  core_io.out                     io
);
  state_t                  state_q, state_d;
  logic [ADDRESSWIDTH-1:0] adr_q, adr_d;
  logic [31:0]             dat_q, dat_d, rdat_q, rdat_d;
  logic [3:0]              sel_q, sel_d;
  logic                    irq_q;
  logic                    oor;
  logic [REGS-1:0]         onehot;
`ifdef WB_CORE_BRIDGE_ERR_EN
  localparam state_t OOR_ST = ERR;
  assign wb_err_o = state_q == ERR && wb_cyc_i;
`else
  localparam state_t OOR_ST = ACK;
  assign wb_err_o = 1'b0;
`endif
  assign oor         = 32'(wb_adr_i) >= REGS;
  assign onehot      = REGS'(1) << adr_q;
  assign io.clk      = clk;
  assign io.reset    = reset;
  // every core-facing and bus-facing strobe is gated by cyc so an abort is silent
  assign io.write_en = (state_q == WRITE && wb_cyc_i) ? onehot : '0;
  assign io.read_en  = (state_q == READ && wb_cyc_i) ? onehot : '0;
  assign io.data_in  = (state_q == WRITE && wb_cyc_i) ? dat_q : '0;
  assign wb_ack_o    = state_q == ACK && wb_cyc_i;
  assign wb_dat_o    = wb_ack_o ? rdat_q : '0;
  assign irq_o       = irq_q;
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    rdat_d  = rdat_q;
    if (state_q != IDLE && !wb_cyc_i) state_d = IDLE;
    else
      case (state_q)
        IDLE: if (wb_cyc_i && wb_stb_i) begin
          adr_d   = wb_adr_i;
          dat_d   = wb_dat_i;
          sel_d   = wb_sel_i;
          rdat_d  = '0;
          state_d = oor ? OOR_ST : !wb_we_i ? READ : wb_sel_i == SEL_FULL ? WRITE : wb_sel_i == 4'h0 ? ACK : RMW;
        end
        READ: begin
          rdat_d  = io.data_out[adr_q];
          state_d = ACK;
        end
        RMW: begin
          dat_d   = byte_merge(io.data_out[adr_q], dat_q, sel_q);
          state_d = WRITE;
        end
        WRITE:   state_d = ACK;
        default: state_d = IDLE;
      endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      rdat_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      rdat_q  <= rdat_d;
      irq_q   <= io.irq_out;
    end
endmodule
